// File: rtl/spike_out_arbiter_if.sv
// Requester-side bus of the spike-out arbiter: per-requester request lines,
// packed spike vectors and a one-hot grant.
//
// Handshake: req_i[k] is a valid flag for slice k of spike_data_i, and gnt_o[k]
// is its ready. A transfer happens on every rising clock edge where
// req_i[k] & gnt_o[k] is 1. The grant is combinational, so the handshake has
// zero latency. A requester keeps req_i[k] and its data stable until it sees a
// grant. In the cycle after the grant it either drops req_i[k] or presents its
// next vector.
interface spike_out_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32
);
  logic [NUM_REQ-1:0]        req_i;
  logic [NUM_REQ*DATA_W-1:0] spike_data_i;
  logic [NUM_REQ-1:0]        gnt_o;

  // Requester side drives requests and data, and observes grants.
  modport master (
    output req_i,
    output spike_data_i,
    input  gnt_o
  );

  // Arbiter side observes requests and data, and drives grants.
  modport slave (
    input  req_i,
    input  spike_data_i,
    output gnt_o
  );
endinterface

// File: rtl/spike_out_arbiter.sv
// Spike-out arbiter.
// This block shares the external write port of the single-word spike-out
// register among NUM_REQ neuron cores. During a timestep it collects spike
// vectors through round-robin req/gnt and OR-merges them into an accumulator.
// After the step closes it drains any late requests. It then commits the merged
// word, but never while a Wishbone access to the register is in flight.
// dbg_state_o exposes the FSM state: 0=IDLE, 1=ACCUM, 2=DRAIN, 3=COMMIT.
module spike_out_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int CNT_W   = 16
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_ni,
  spike_out_arbiter_if.slave   req_bus,
  input  logic                 step_start_i,
  input  logic                 step_end_i,
  input  logic                 bus_busy_i,
  output logic [DATA_W-1:0]    spike_data_o,
  output logic                 spike_write_en_o,
  output logic                 commit_done_o,
  output logic                 busy_o,
  output logic                 overrun_o,
  output logic [CNT_W-1:0]     step_cnt_o,
  output logic [1:0]           dbg_state_o
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCUM  = 2'd1,
    S_DRAIN  = 2'd2,
    S_COMMIT = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [PTR_W-1:0]   r_ptr;
  logic [PTR_W-1:0]   w_ptr_nxt;
  logic [PTR_W-1:0]   w_gnt_idx;
  logic               w_gnt_any;
  logic               w_arb_en;
  logic               w_clr_acc;
  logic               w_commit;
  logic               w_overrun_set;
  logic [NUM_REQ-1:0] w_gnt;
  logic [DATA_W-1:0]  w_gnt_data;
  logic [DATA_W-1:0]  r_acc;
  logic               r_commit_done;
  logic               r_overrun;
  logic [CNT_W-1:0]   r_step_cnt;

  // Wraps (base + off) into 0..NUM_REQ-1. off is always below NUM_REQ, so one
  // subtraction is enough.
  function automatic logic [PTR_W-1:0] rr_index(input logic [PTR_W-1:0] base,
                                                input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return PTR_W'(s);
  endfunction

  // Grants are only handed out while the step is open or draining.
  assign w_arb_en = (r_state == S_ACCUM) || (r_state == S_DRAIN);

  // Round-robin search: the first active request at or after the pointer wins.
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    if (w_arb_en) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!w_gnt_any && req_bus.req_i[rr_index(r_ptr, i)]) begin
          w_gnt_any = 1'b1;
          w_gnt_idx = rr_index(r_ptr, i);
        end
      end
    end
  end

  // Convert the winning index into the one-hot grant.
  always_comb begin
    w_gnt = '0;
    if (w_gnt_any) w_gnt[w_gnt_idx] = 1'b1;
  end

  assign req_bus.gnt_o = w_gnt;
  assign w_gnt_data    = req_bus.spike_data_i[int'(w_gnt_idx) * DATA_W +: DATA_W];
  assign w_ptr_nxt     = (w_gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;

  // Next-state and step-control decode. A step_start seen outside IDLE only
  // flags an overrun.
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_acc     = 1'b0;
    w_commit      = 1'b0;
    w_overrun_set = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (step_start_i) begin
          w_state_nxt = S_ACCUM;
          w_clr_acc   = 1'b1;
        end
      end
      S_ACCUM: begin
        w_overrun_set = step_start_i;
        if (step_end_i) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        w_overrun_set = step_start_i;
        if (req_bus.req_i == '0) w_state_nxt = S_COMMIT;
      end
      S_COMMIT: begin
        w_overrun_set = step_start_i;
        if (!bus_busy_i) begin
          w_commit    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) r_state <= S_IDLE;
    else            r_state <= w_state_nxt;
  end

  // The round-robin pointer moves just past each granted requester.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni)     r_ptr <= '0;
    else if (w_gnt_any) r_ptr <= w_ptr_nxt;
  end

  // Accumulator: cleared when a step opens, OR-merged on every transfer.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni)     r_acc <= '0;
    else if (w_clr_acc) r_acc <= '0;
    else if (w_gnt_any) r_acc <= r_acc | w_gnt_data;
  end

  // Commit status: done pulse, sticky overrun and the step counter (wraps).
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_commit_done <= 1'b0;
      r_overrun     <= 1'b0;
      r_step_cnt    <= '0;
    end else begin
      r_commit_done <= w_commit;
      if (w_overrun_set) r_overrun  <= 1'b1;
      if (w_commit)      r_step_cnt <= r_step_cnt + 1'b1;
    end
  end

  // The write enable is combinational so that it drops in the same cycle bus_busy_i rises.
  assign spike_write_en_o = w_commit;
  assign spike_data_o     = r_acc;
  assign commit_done_o    = r_commit_done;
  assign busy_o           = (r_state != S_IDLE);
  assign overrun_o        = r_overrun;
  assign step_cnt_o       = r_step_cnt;
  assign dbg_state_o      = r_state;

endmodule
